fifo_wctrl: RTL and testbench

Write-side control block for the asynchronous FIFO, running entirely in the write clock domain. Owns the binary/Gray write pointer, brings the read domain's Gray read pointer into `wclk` through a two-flop synchronizer, and produces the full, almost-full, fill-level and overflow status seen by the FIFO producer. Its outputs drive the dual-port memory write address and the `wptr` bus that the read-domain synchronizer samples.

---
 rtl/fifo_wctrl.sv | 109 ++++++++++
 tb/tb_fifo_wctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_wctrl.sv
// fifo_wctrl: write-side control of the asynchronous FIFO, entirely in the wclk domain.
// Owns the binary/Gray write pointer and synchronizes the Gray read pointer through two flops.
// It also produces the full, almost-full, fill-level and sticky overflow status.
// Optional feature macro: FIFO_WALMOST_FULL_EN. When it is undefined, walmost_full is tied
// to 0 and its comparator is removed.
//
// Handshake: winc is a write request for the current cycle. wen = winc & ~wfull is the
// acceptance. A write is taken on the wclk edge where wen=1, and that edge advances wptr/waddr.
// A request made while wfull=1 is dropped and leaves the pointer unchanged. Such a request
// sets woverflow on the next edge, and woverflow stays set until reset.
module fifo_wctrl #(
  parameter int ADDRSIZE     = 4,
  parameter int AFULL_THRESH = 14
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   rptr,
  output logic [ADDRSIZE:0]   wptr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic                wen,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                woverflow
);

  logic [ADDRSIZE:0] wbin;
  logic [ADDRSIZE:0] wq1_rptr;
  logic [ADDRSIZE:0] wq2_rptr;
  logic [ADDRSIZE:0] wq2_rbin;
  logic [ADDRSIZE:0] wbinnext;
  logic [ADDRSIZE:0] wgraynext;
  logic [ADDRSIZE:0] wdiff;
  logic [ADDRSIZE:0] full_match;

  assign wen   = winc & ~wfull;
  assign waddr = wbin[ADDRSIZE-1:0];

  // Next pointer, in binary and Gray. The binary value wraps naturally at 2^(ADDRSIZE+1).
  always_comb begin
    wbinnext  = wbin + {{ADDRSIZE{1'b0}}, wen};
    wgraynext = (wbinnext >> 1) ^ wbinnext;
  end

  // Gray-to-binary of the synchronized read pointer. Each bit is the XOR of itself and all higher bits.
  always_comb begin
    wq2_rbin = '0;
    wq2_rbin[ADDRSIZE] = wq2_rptr[ADDRSIZE];
    for (int i = ADDRSIZE - 1; i >= 0; i--) begin
      wq2_rbin[i] = wq2_rbin[i+1] ^ wq2_rptr[i];
    end
  end

  // Occupancy seen against the (possibly stale) read pointer, and the Gray full pattern.
  always_comb begin
    wdiff      = wbinnext - wq2_rbin;
    full_match = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};
  end

  // Two-flop synchronizer bringing the read pointer into wclk.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wq1_rptr <= '0;
      wq2_rptr <= '0;
    end else begin
      wq1_rptr <= rptr;
      wq2_rptr <= wq1_rptr;
    end
  end

  // Write pointer registers. They load every edge and only move when a write is accepted.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin <= '0;
      wptr <= '0;
    end else begin
      wbin <= wbinnext;
      wptr <= wgraynext;
    end
  end

  // Full, level and sticky overflow status. These flags are pessimistic while a read is still in the synchronizer.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wfull     <= 1'b0;
      wlevel    <= '0;
      woverflow <= 1'b0;
    end else begin
      wfull     <= (wgraynext == full_match);
      wlevel    <= wdiff;
      woverflow <= woverflow | (winc & wfull);
    end
  end

`ifdef FIFO_WALMOST_FULL_EN
  // Almost-full threshold register.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      walmost_full <= 1'b0;
    end else begin
      walmost_full <= (wdiff >= (ADDRSIZE+1)'(AFULL_THRESH));
    end
  end
`else
  assign walmost_full = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wctrl.sv
// tb_fifo_wctrl: directed and randomized checks of fifo_wctrl against a count-based model.
// The expected almost-full behaviour follows FIFO_WALMOST_FULL_EN in the same way as the DUT.
module tb_fifo_wctrl;

  localparam int ADDRSIZE = 4;
  localparam int DEPTH    = 16;
  localparam int THRESH   = 14;

  // ---------------- clock / reset ----------------
  logic                wclk = 1'b0;
  logic                wrst_n = 1'b0;
  logic                winc = 1'b0;
  logic [ADDRSIZE:0]   rptr = '0;
  logic [ADDRSIZE:0]   wptr;
  logic [ADDRSIZE-1:0] waddr;
  logic                wen;
  logic                wfull;
  logic                walmost_full;
  logic [ADDRSIZE:0]   wlevel;
  logic                woverflow;

  always #5 wclk = ~wclk;

  fifo_wctrl #(.ADDRSIZE(ADDRSIZE), .AFULL_THRESH(THRESH)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .rptr(rptr),
    .wptr(wptr), .waddr(waddr), .wen(wen), .wfull(wfull),
    .walmost_full(walmost_full), .wlevel(wlevel), .woverflow(woverflow)
  );

  // ---------------- reference model (plain counts) ----------------
  int unsigned checks = 0;
  int unsigned errors = 0;
  int  wcount;            // total writes accepted since reset
  int  rcount;            // total reads performed by the read side
  int  syn1, syn2;        // read counts as seen one and two wclk edges after sampling
  bit  m_full, m_almost, m_ovf;
  int  m_level;
  bit  af_enabled;
  int  exp_q[$];          // read counts pending in the synchronizer, oldest first

  function automatic logic [ADDRSIZE:0] to_gray(input int n);
    logic [ADDRSIZE:0] b;
    b = (ADDRSIZE+1)'(n % (2*DEPTH));
    return b ^ (b >> 1);
  endfunction

  task automatic model_reset();
    wcount = 0; rcount = 0; syn1 = 0; syn2 = 0;
    m_full = 0; m_almost = 0; m_ovf = 0; m_level = 0;
    exp_q.delete();
    exp_q.push_back(0);
    exp_q.push_back(0);
  endtask

  // One wclk edge, using the inputs that were present before it.
  task automatic model_edge(input bit w);
    bit acc;
    int seen;
    acc   = w && !m_full;
    seen  = exp_q.pop_front();        // read count that is registered in the second stage now
    m_ovf = m_ovf || (w && m_full);
    if (acc) wcount++;
    m_level  = wcount - seen;
    m_full   = (m_level == DEPTH);
    m_almost = af_enabled && (m_level >= THRESH);
    exp_q.push_back(rcount);
    syn2 = seen;
    syn1 = rcount;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".wptr"},  32'(wptr),  32'(to_gray(wcount)));
    chk({tag, ".waddr"}, 32'(waddr), 32'(wcount % DEPTH));
    chk({tag, ".wfull"}, 32'(wfull), 32'(m_full));
    chk({tag, ".wlevel"}, 32'(wlevel), 32'(m_level % (2*DEPTH)));
    chk({tag, ".walmost"}, 32'(walmost_full), 32'(m_almost));
    chk({tag, ".wovf"}, 32'(woverflow), 32'(m_ovf));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".wptr"}, 32'(wptr), 0);
    chk({tag, ".waddr"}, 32'(waddr), 0);
    chk({tag, ".wen"}, 32'(wen), 0);
    chk({tag, ".wfull"}, 32'(wfull), 0);
    chk({tag, ".walmost"}, 32'(walmost_full), 0);
    chk({tag, ".wlevel"}, 32'(wlevel), 0);
    chk({tag, ".wovf"}, 32'(woverflow), 0);
  endtask

  // ---------------- driver tasks ----------------
  // The caller is at a negedge. This task drives the inputs, checks wen, runs one edge, then checks at the next negedge.
  task automatic tick(input bit w, input string tag);
    winc = w;
    rptr = to_gray(rcount);
    #1;
    chk({tag, ".wen"}, 32'(wen), 32'(w && !m_full));
    @(posedge wclk);
    model_edge(w);
    @(negedge wclk);
    chk_all(tag);
  endtask

  // Asserts reset away from an edge and checks it without waiting for a clock.
  task automatic do_reset(input string tag);
    winc = 1'b0;
    #2;
    wrst_n = 1'b0;
    #1;
    chk_zero({tag, ".async"});
    repeat (2) @(posedge wclk);
    @(negedge wclk);
    chk_zero({tag, ".held"});
    model_reset();
    rptr = '0;
    wrst_n = 1'b1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int hist[$];
`ifdef FIFO_WALMOST_FULL_EN
    af_enabled = 1'b1;
`else
    af_enabled = 1'b0;
`endif
    model_reset();
    @(negedge wclk);
    do_reset("rst0");

    // Fill to full with no reads.
    for (int i = 1; i <= DEPTH; i++) tick(1'b1, $sformatf("fill%0d", i));
    chk("fill.wptr", 32'(wptr), 32'b11000);
    chk("fill.wlevel", 32'(wlevel), 16);
    chk("fill.waddr", 32'(waddr), 0);
    chk("fill.wfull", 32'(wfull), 1);

    // Writes while full are dropped and set the sticky overflow flag.
    for (int i = 0; i < 3; i++) tick(1'b1, $sformatf("ovf%0d", i));
    chk("ovf.wptr", 32'(wptr), 32'b11000);
    chk("ovf.flag", 32'(woverflow), 1);

    // One read releases full after the synchronizer latency.
    rcount = 1;
    tick(1'b0, "rel1");
    tick(1'b0, "rel2");
    chk("rel2.wfull", 32'(wfull), 1);
    tick(1'b0, "rel3");
    chk("rel3.wfull", 32'(wfull), 0);
    chk("rel3.wlevel", 32'(wlevel), 15);

    // Reset in the middle of a stream, while wbin is 7.
    do_reset("rst1");
    for (int i = 0; i < 7; i++) tick(1'b1, "pre");
    chk("pre.waddr", 32'(waddr), 7);
    do_reset("rst2");

    // Wrap-around: the read side follows the write count with a 4-cycle lag.
    for (int i = 0; i < 40; i++) begin
      hist.push_back(wcount);
      if (hist.size() > 4) rcount = hist.pop_front();
      tick(1'b1, "wrap");
      chk("wrap.nofull", 32'(wfull), 0);
    end
    chk("wrap.wptr", 32'(wptr), 32'b01100);

    // Random writes and random, legal, single-step reads.
    for (int i = 0; i < 400; i++) begin
      if (rcount < wcount && $urandom_range(0, 99) < 45) rcount++;
      tick(1'($urandom_range(0, 99) < 60), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
